// File: rtl/poly_dec_fir_mac.sv
// Decimating FIR with run-time coefficients: one output per DEC input beats,
// computed by a single time-shared multiply-accumulate, then rounded, shifted and saturated.
module poly_dec_fir_mac #(
  parameter int IN_W   = 8,
  parameter int COEF_W = 12,
  parameter int NTAPS  = 21,
  parameter int DEC    = 2,
  parameter int SHIFT  = 0,
  parameter int OUT_W  = 20
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [IN_W-1:0]     in_data,
  input  logic                       coef_we,
  input  logic [$clog2(NTAPS)-1:0]   coef_addr,
  input  logic signed [COEF_W-1:0]   coef_data,
  output logic                       coef_err,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [OUT_W-1:0]    out_data,
  output logic                       out_sat
);

  localparam int ACC_W  = IN_W + COEF_W + $clog2(NTAPS);
  localparam int CAW    = $clog2(NTAPS);
  localparam int PW     = (DEC > 1) ? $clog2(DEC) : 1;
  localparam int PROD_W = IN_W + COEF_W;
  // One guard bit above the accumulator so the rounding add cannot wrap.
  localparam int RW     = (ACC_W + 1 > OUT_W) ? ACC_W + 1 : OUT_W;

  localparam logic signed [RW-1:0] RND     = (RW'(1) << SHIFT) >> 1;
  localparam logic signed [RW-1:0] SAT_MAX = {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [RW-1:0] SAT_MIN = {{(RW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                    state;
  state_t                    state_nxt;
  logic signed [IN_W-1:0]    dly  [NTAPS];
  logic signed [COEF_W-1:0]  coef [NTAPS];
  logic [PW-1:0]             phase;
  logic [CAW-1:0]            k;
  logic signed [ACC_W-1:0]   acc;
  logic                      beat;
  logic                      dec_beat;
  logic                      coef_ok;
  logic                      coef_wr;
  logic signed [PROD_W-1:0]  prod;
  logic [OUT_W:0]            sat_res;

  function automatic logic signed [RW-1:0] round_shift(input logic signed [ACC_W-1:0] a);
    logic signed [RW-1:0] w;
    w = RW'(a) + RND;
    return w >>> SHIFT;
  endfunction

  // Returns {clamped_flag, value}.
  function automatic logic [OUT_W:0] saturate(input logic signed [RW-1:0] r);
    if (r > SAT_MAX) return {1'b1, SAT_MAX[OUT_W-1:0]};
    if (r < SAT_MIN) return {1'b1, SAT_MIN[OUT_W-1:0]};
    return {1'b0, r[OUT_W-1:0]};
  endfunction

  assign in_ready = (state == IDLE) && !reset;
  assign beat     = in_valid && in_ready;
  assign dec_beat = beat && (phase == PW'(DEC - 1));
  assign coef_ok  = int'(coef_addr) < NTAPS;
  assign coef_wr  = coef_we && (state == IDLE) && coef_ok;
  assign prod     = PROD_W'(dly[k]) * PROD_W'(coef[k]);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (dec_beat) state_nxt = MAC;
      MAC:     if (k == CAW'(NTAPS - 1)) state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage: sample capture, coefficient update and MAC accumulation.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NTAPS; i++) begin
        dly[i]  <= '0;
        coef[i] <= '0;
      end
      phase    <= '0;
      k        <= '0;
      acc      <= '0;
      coef_err <= 1'b0;
    end else begin
      coef_err <= coef_we && !coef_wr;
      if (coef_wr) coef[coef_addr] <= coef_data;
      if (beat) begin
        for (int i = NTAPS - 1; i > 0; i--) dly[i] <= dly[i-1];
        dly[0] <= in_data;
        if (dec_beat) begin
          phase <= '0;
          acc   <= '0;
          k     <= '0;
        end else begin
          phase <= phase + PW'(1);
        end
      end
      if (state == MAC) begin
        acc <= acc + ACC_W'(prod);
        k   <= k + CAW'(1);
      end
    end
  end

  // Stage: output formatting; acc is frozen while OUT waits for out_ready.
  assign sat_res   = saturate(round_shift(acc));
  assign out_valid = (state == OUT) && !reset;
  assign out_data  = out_valid ? $signed(sat_res[OUT_W-1:0]) : '0;
  assign out_sat   = out_valid && sat_res[OUT_W];

endmodule

// File: tb/tb_poly_dec_fir_mac.sv
// Scoreboard bench for poly_dec_fir_mac: a sample-history reference model queues expected
// outputs per decimating beat; a monitor pops them on each output transfer.
module tb_poly_dec_fir_mac;
  localparam int IN_W   = 8;
  localparam int COEF_W = 12;
  localparam int NTAPS  = 21;
  localparam int DEC    = 2;
  localparam int SHIFT  = 0;
  localparam int OUT_W  = 20;
  localparam int CAW    = $clog2(NTAPS);

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      in_valid;
  logic                      in_ready;
  logic signed [IN_W-1:0]    in_data;
  logic                      coef_we;
  logic [CAW-1:0]            coef_addr;
  logic signed [COEF_W-1:0]  coef_data;
  logic                      coef_err;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [OUT_W-1:0]   out_data;
  logic                      out_sat;

  poly_dec_fir_mac #(.IN_W(IN_W), .COEF_W(COEF_W), .NTAPS(NTAPS), .DEC(DEC),
                     .SHIFT(SHIFT), .OUT_W(OUT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_err(coef_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { longint data; bit sat; int cyc; } exp_t;
  exp_t q[$];
  int   hist[$];
  int   cf[NTAPS];
  int   ph = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   bp_mode = 0;   // 0: ready, 1: random, 2: stalled
  bit   last_dec;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    foreach (cf[i]) cf[i] = 0;
    ph = 0;
    q.delete();
  endtask

  // Reference: newest sample is hist[0]; every DEC-th beat produces sum(hist[i]*cf[i]).
  function automatic bit model_beat(input int x, input int c);
    longint acc, r, rnd, mx, mn;
    exp_t e;
    hist.push_front(x);
    if (hist.size() > NTAPS) void'(hist.pop_back());
    if (ph != DEC - 1) begin
      ph++;
      return 1'b0;
    end
    ph  = 0;
    acc = 0;
    for (int i = 0; i < hist.size(); i++) acc += longint'(hist[i]) * longint'(cf[i]);
    rnd = (longint'(1) << SHIFT) / 2;
    r   = (acc + rnd) >>> SHIFT;
    mx  = (longint'(1) << (OUT_W - 1)) - 1;
    mn  = -mx - 1;
    e.sat = 1'b0;
    if (r > mx) begin r = mx; e.sat = 1'b1; end
    else if (r < mn) begin r = mn; e.sat = 1'b1; end
    e.data = r;
    e.cyc  = c;
    q.push_back(e);
    return 1'b1;
  endfunction

  task automatic wait_idle(output bit ok);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 400) begin
      @(negedge clk);
      t++;
    end
    ok = in_ready;
    if (!ok) chk("wait_in_ready_timeout", 0, 1);
  endtask

  task automatic send_w(input int x, input bit we, input int addr, input int cval);
    bit ok;
    wait_idle(ok);
    if (!ok) return;
    in_valid = 1'b1;
    in_data  = IN_W'(x);
    if (we) begin
      coef_we   = 1'b1;
      coef_addr = CAW'(addr);
      coef_data = COEF_W'(cval);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    coef_we  = 1'b0;
    if (we && addr < NTAPS) cf[addr] = cval;
    last_dec = model_beat(x, cyc);
  endtask

  task automatic send(input int x);
    send_w(x, 1'b0, 0, 0);
  endtask

  task automatic wcoef(input int addr, input int val);
    bit ok;
    wait_idle(ok);
    if (!ok) return;
    coef_we   = 1'b1;
    coef_addr = CAW'(addr);
    coef_data = COEF_W'(val);
    @(posedge clk);
    #1;
    coef_we = 1'b0;
    chk("coef_err_idle_write", longint'(coef_err), (addr >= NTAPS) ? 1 : 0);
    if (addr < NTAPS) cf[addr] = val;
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() > 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (q.size() > 0) chk("drain_timeout", longint'(q.size()), 0);
    repeat (2) @(negedge clk);
    chk("idle_after_drain", longint'(in_ready), 1);
  endtask

  // Backpressure driver.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        1:       out_ready = 1'($urandom_range(0, 1));
        2:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: pop and compare on each transfer, check latency and hold stability.
  initial begin
    bit pend = 1'b0;
    bit after_x = 1'b0;
    longint hold_d = 0;
    bit hold_s = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        pend = 1'b0;
        after_x = 1'b0;
      end else begin
        if (after_x) chk("valid_low_after_transfer", longint'(out_valid), 0);
        after_x = 1'b0;
        if (pend && !out_valid) chk("valid_dropped_while_stalled", 0, 1);
        if (out_valid) begin
          if (pend) begin
            chk("stall_data_stable", longint'(out_data), hold_d);
            chk("stall_sat_stable", longint'(out_sat), longint'(hold_s));
          end else if (q.size() == 0) begin
            chk("unexpected_output", longint'(out_data), -1);
          end else begin
            chk("latency", longint'(cyc), longint'(q[0].cyc + NTAPS));
          end
          if (out_ready) begin
            if (q.size() > 0) begin
              e = q.pop_front();
              chk("out_data", longint'(out_data), e.data);
              chk("out_sat", longint'(out_sat), longint'(e.sat));
            end
            pend = 1'b0;
            after_x = 1'b1;
          end else begin
            pend = 1'b1;
            hold_d = longint'(out_data);
            hold_s = out_sat;
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    reset = 1'b1; in_valid = 1'b0; in_data = '0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("in_ready_during_reset", longint'(in_ready), 0);
    chk("out_valid_during_reset", longint'(out_valid), 0);
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", longint'(in_ready), 1);
    chk("reset_out_valid", longint'(out_valid), 0);
    chk("reset_out_data", longint'(out_data), 0);
    chk("reset_out_sat", longint'(out_sat), 0);
    chk("reset_coef_err", longint'(coef_err), 0);

    // Zero coefficients: outputs are zero.
    repeat (4) send(5);
    drain();

    // Impulse through ramp coefficients.
    for (int i = 0; i < NTAPS; i++) wcoef(i, i + 1);
    send(1);
    repeat (21) send(0);
    drain();

    // Unit coefficients, constant input.
    for (int i = 0; i < NTAPS; i++) wcoef(i, 1);
    repeat (42) send(3);
    drain();

    // Output held under backpressure.
    bp_mode = 2;
    t = 0;
    do begin send(7); t++; end while (!last_dec && t < 4);
    t = 0;
    while (!out_valid && t < 100) begin @(negedge clk); t++; end
    chk("stall_out_valid_seen", longint'(out_valid), 1);
    repeat (10) begin
      @(negedge clk);
      chk("stall_in_ready_low", longint'(in_ready), 0);
    end
    bp_mode = 0;
    drain();

    // Saturation both ways.
    for (int i = 0; i < NTAPS; i++) wcoef(i, 2047);
    repeat (24) send(127);
    drain();
    repeat (24) send(-128);
    drain();

    // Rejected writes: out-of-range address, and a write during MAC.
    wcoef(NTAPS, 5);
    @(posedge clk); #1;
    chk("coef_err_pulse_len", longint'(coef_err), 0);
    t = 0;
    do begin send(2); t++; end while (!last_dec && t < 4);
    coef_we = 1'b1; coef_addr = CAW'(0); coef_data = COEF_W'(-1000);
    @(posedge clk); #1;
    coef_we = 1'b0;
    chk("coef_err_in_mac", longint'(coef_err), 1);
    @(posedge clk); #1;
    chk("coef_err_one_cycle", longint'(coef_err), 0);
    drain();

    // Write in the same cycle as the decimating beat takes effect immediately.
    t = 0;
    while (ph != DEC - 1 && t < DEC) begin send(0); t++; end
    send_w(10, 1'b1, 0, 100);
    drain();

    // Reset during MAC aborts the output and clears coefficients.
    t = 0;
    do begin send(50); t++; end while (!last_dec && t < 4);
    repeat (4) @(posedge clk);
    #1; reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1; reset = 1'b0;
    repeat (4) send($urandom_range(0, 255) - 128);
    drain();

    // Randomized coefficients, data and backpressure.
    for (int i = 0; i < NTAPS; i++) wcoef(i, $urandom_range(0, 4095) - 2048);
    bp_mode = 1;
    for (int n = 0; n < 60; n++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      send($urandom_range(0, 255) - 128);
    end
    bp_mode = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
